axis_byte_rr_arbiter: RTL and testbench
=======================================

// Module: axis_byte_rr_arbiter
// PURPOSE
//   Packet-level round-robin arbiter sharing one 8-bit AXI-Stream byte lane (the
//   input side of the 8->32 packer) between NUM_SRC byte-stream requesters.
//   The grant is locked for a whole packet, so packets are never interleaved.
//   Oversized packets are truncated at MAX_PKT_LEN with a forced tlast; the rest
//   of that packet is drained and discarded. Sits in the clk_8 domain.
// PARAMETERS
//   NUM_SRC      4     number of requesters (2..16)
//   MAX_PKT_LEN  1024  max bytes per packet forwarded downstream (>=2)
//   SRC_W        $clog2(NUM_SRC)        width of m_tid (derived, do not override)
//   CNT_W        $clog2(MAX_PKT_LEN+1)  width of byte counter (derived)
// PORTS
//   clk_8       in   1          byte-lane clock
//   reset_8     in   1          asynchronous, active-high reset
//   s_tdata     in   NUM_SRC*8  requester bytes, src i on [8i+7:8i]
//   s_tvalid    in   NUM_SRC    requester valid
//   s_tlast     in   NUM_SRC    requester end-of-packet
//   s_tready    out  NUM_SRC    requester ready (at most one bit high)
//   m_tdata     out  8          byte to packer
//   m_tvalid    out  1          valid to packer
//   m_tlast     out  1          end-of-packet to packer (forced on truncation)
//   m_tready    in   1          packer ready (packer FIFO not full)
//   m_tid       out  SRC_W      index of granted source, stable for whole packet
//   busy        out  1          1 while in XFER or DROP
//   pkt_done    out  1          1-cycle pulse: packet completed normally
//   trunc_err   out  1          1-cycle pulse: packet truncated at MAX_PKT_LEN
// BEHAVIOUR
//   Reset: state=IDLE, grant=0, last_grant=NUM_SRC-1 (src 0 wins first arb),
//     byte_cnt=0; all outputs 0. Reset mid-packet aborts; nothing more emitted.
//   Handshake = m_tvalid & m_tready (XFER) or s_tvalid[g] & s_tready[g] (DROP).
//   FSM states IDLE, XFER, DROP:
//   IDLE: m_tvalid=0, s_tready=0. If any s_tvalid: grant <= first requester
//     after last_grant in ascending modulo order; byte_cnt<=0; -> XFER next
//     cycle (one-cycle arbitration bubble per packet).
//   XFER: zero-latency combinational path from granted source g:
//     m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], m_tlast=s_tlast[g],
//     s_tready[g]=m_tready, other s_tready=0. Grant held even if s_tvalid[g]
//     drops mid-packet; other requesters wait.
//     On handshake: byte_cnt++.
//     - s_tlast[g]: pkt_done pulse next cycle, last_grant<=g, -> IDLE.
//     - else byte_cnt==MAX_PKT_LEN-1: m_tlast forced 1 this cycle, trunc_err
//       pulse next cycle, -> DROP.
//     - s_tlast wins if both (exactly MAX_PKT_LEN bytes is legal, no error).
//   DROP: m_tvalid=0, m_tlast=0, s_tready[g]=1; bytes discarded. On handshake
//     with s_tlast[g]: last_grant<=g, -> IDLE. No pkt_done for dropped packet.
//   m_tid = grant, valid while busy; busy=1 in XFER/DROP.
//   m_tvalid never depends on m_tready (AXIS rule); m_tdata/tlast held while
//     m_tvalid=1 & m_tready=0 provided the source obeys AXIS.
//   Single-byte packets (tlast on first byte) complete in XFER in one beat.
//   byte_cnt never wraps: cleared on entry to XFER, max value MAX_PKT_LEN-1.
// TESTING
//   1 Src0 only, 5-byte pkt 0x01..0x05, m_tready=1 -> m_tdata 01..05, m_tlast on
//     05, m_tid=0, one pkt_done pulse, s_tready[1..3]=0 throughout.
//   2 Src0..3 all request 3-byte pkts continuously after reset -> grant order
//     0,1,2,3,0; no byte interleaving; one idle cycle between packets.
//   3 Src2 sends 1030-byte pkt (MAX=1024) -> 1024 bytes out, m_tlast on byte
//     1024, trunc_err pulse, remaining 6 bytes accepted (s_tready[2]=1) and not
//     output, then IDLE.
//   4 Exactly 1024-byte pkt -> m_tlast on byte 1024 from source, pkt_done=1,
//     trunc_err=0.
//   5 m_tready toggled 1,0,0,1 and s_tvalid[g] gapped mid-packet -> no lost or
//     duplicated bytes, m_tid stable, s_tready[g] tracks m_tready.
//   6 Assert reset_8 on byte 3 of a packet -> outputs 0 asynchronously; after
//     release src 0 wins next arbitration.

Source files
------------

// File: rtl/axis_byte_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream byte lane between
// NUM_SRC requesters; grant is held per packet, oversized packets are truncated.
module axis_byte_rr_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned MAX_PKT_LEN = 1024,
  localparam int unsigned SRC_W      = $clog2(NUM_SRC),
  localparam int unsigned CNT_W      = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                 clk_8,
  input  logic                 reset_8,
  input  logic [NUM_SRC*8-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]   s_tvalid,
  input  logic [NUM_SRC-1:0]   s_tlast,
  output logic [NUM_SRC-1:0]   s_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [SRC_W-1:0]     m_tid,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 trunc_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);

  logic [1:0]       state, state_nxt;
  logic [SRC_W-1:0] grant, grant_nxt;
  logic [SRC_W-1:0] last_grant, last_grant_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic             pkt_done_nxt, trunc_err_nxt;

  logic [7:0]       src_data [NUM_SRC];
  logic             arb_found;
  logic [SRC_W-1:0] arb_src;
  int unsigned      cand;
  logic             xfer_hs, drop_hs, at_limit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = s_tdata[8*i +: 8];
  end

  // First requester after last_grant, ascending modulo NUM_SRC.
  always_comb begin
    arb_found = 1'b0;
    arb_src   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(last_grant) + k) % NUM_SRC;
      if (!arb_found && s_tvalid[SRC_W'(cand)]) begin
        arb_found = 1'b1;
        arb_src   = SRC_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_8 or posedge reset_8) begin
    if (reset_8) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
      byte_cnt   <= '0;
      pkt_done   <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      byte_cnt   <= byte_cnt_nxt;
      pkt_done   <= pkt_done_nxt;
      trunc_err  <= trunc_err_nxt;
    end
  end

  assign at_limit = (byte_cnt == CNT_LAST);
  assign xfer_hs  = (state == ST_XFER) && s_tvalid[grant] && m_tready;
  assign drop_hs  = (state == ST_DROP) && s_tvalid[grant];

  // Next state plus the zero-latency byte-lane mux.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    byte_cnt_nxt   = byte_cnt;
    pkt_done_nxt   = 1'b0;
    trunc_err_nxt  = 1'b0;
    m_tdata        = '0;
    m_tvalid       = 1'b0;
    m_tlast        = 1'b0;
    s_tready       = '0;

    case (state)
      ST_IDLE: begin
        if (arb_found) begin
          grant_nxt    = arb_src;
          byte_cnt_nxt = '0;
          state_nxt    = ST_XFER;
        end
      end
      ST_XFER: begin
        m_tdata         = src_data[grant];
        m_tvalid        = s_tvalid[grant];
        m_tlast         = s_tlast[grant] | at_limit;
        s_tready[grant] = m_tready;
        if (xfer_hs) begin
          if (s_tlast[grant]) begin
            pkt_done_nxt   = 1'b1;
            last_grant_nxt = grant;
            state_nxt      = ST_IDLE;
          end else if (at_limit) begin
            trunc_err_nxt = 1'b1;
            state_nxt     = ST_DROP;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end
      ST_DROP: begin
        s_tready[grant] = 1'b1;
        if (drop_hs && s_tlast[grant]) begin
          last_grant_nxt = grant;
          state_nxt      = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign m_tid = grant;
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_axis_byte_rr_arbiter.sv
// Bench for axis_byte_rr_arbiter: queue-based source drivers and a packet
// scoreboard that predicts bytes, tlast, truncation and round-robin order.
module tb_axis_byte_rr_arbiter;

  localparam int NS  = 4;
  localparam int MAX = 1024;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic          clk_8 = 1'b0;
  logic          reset_8;
  logic [NS*8-1:0] s_tdata;
  logic [NS-1:0] s_tvalid, s_tlast, s_tready;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    m_tid;
  logic          busy, pkt_done, trunc_err;

  axis_byte_rr_arbiter #(.NUM_SRC(NS), .MAX_PKT_LEN(MAX)) dut (
    .clk_8(clk_8), .reset_8(reset_8),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .m_tid(m_tid), .busy(busy), .pkt_done(pkt_done), .trunc_err(trunc_err)
  );

  always #5 clk_8 = ~clk_8;

  beat_t src_q [NS][$];
  beat_t exp_q [NS][$];

  int checks = 0, errors = 0, cyc = 0;
  int gap_pct = 0, stall_pct = 0;
  bit rdy_mode = 0;
  logic [3:0] rdy_pat;
  logic [NS-1:0] s_hs = '0;
  bit in_pkt = 0, rr_check = 0, gap_check = 0, have_end = 0;
  bit pend_done = 0, pend_trunc = 0;
  int pos = 0, pkt_tid = 0, prev_tid = 0, last_end = 0;
  int n_done = 0, n_trunc = 0, n_beats = 0;
  int d0, t0, b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int src, input int len, input int base);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = (base < 0) ? 8'($urandom) : 8'(base + j);
      b.last = (j == len - 1);
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[8*i +: 8] = 8'h00;
      end else begin
        // An offered beat stays offered until it is taken.
        if (!(s_tvalid[i] && !s_hs[i])) s_tvalid[i] = ($urandom_range(99) >= gap_pct);
        s_tdata[8*i +: 8] = src_q[i][0].data;
        s_tlast[i]        = src_q[i][0].last;
      end
    end
    if (rdy_mode) m_tready = rdy_pat[cyc % 4];
    else          m_tready = ($urandom_range(99) >= stall_pct);
  endtask

  task automatic monitor();
    int t;
    beat_t e, d;
    bit exp_last;
    t = int'(m_tid);
    n_beats++;
    if (!in_pkt) begin
      in_pkt = 1; pos = 0; pkt_tid = t;
      if (rr_check)  chk("rr_order", 32'(t), 32'((prev_tid + 1) % NS));
      if (gap_check && have_end) chk("arb_bubble", 32'(cyc - last_end), 32'd2);
      prev_tid = t;
    end else begin
      chk("tid_stable", 32'(t), 32'(pkt_tid));
    end
    chk("beat_expected", 32'(exp_q[t].size() != 0), 32'd1);
    if (exp_q[t].size() != 0) begin
      e = exp_q[t].pop_front();
      pos++;
      exp_last = e.last || (pos == MAX);
      chk("m_tdata", 32'(m_tdata), 32'(e.data));
      chk("m_tlast", 32'(m_tlast), 32'(exp_last));
      if (exp_last) begin
        in_pkt = 0; last_end = cyc; have_end = 1;
        if (e.last) pend_done = 1;
        else begin
          pend_trunc = 1;
          while (exp_q[t].size() != 0) begin
            d = exp_q[t].pop_front();
            if (d.last) break;
          end
        end
      end
    end
  endtask

  // Called at posedge+1: sample mid-cycle, cross the edge, check pulses, redrive.
  task automatic cycle();
    logic [NS-1:0] hs;
    #4;
    if (busy) chk("rdy_grant_only", 32'(s_tready & ~(4'b0001 << m_tid)), 32'd0);
    else begin
      chk("rdy_idle", 32'(s_tready), 32'd0);
      chk("mvalid_idle", 32'(m_tvalid), 32'd0);
    end
    if (m_tvalid) chk("rdy_track", 32'(s_tready[m_tid]), 32'(m_tready));
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) monitor();
    @(posedge clk_8); #1;
    cyc++;
    for (int i = 0; i < NS; i++)
      if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    s_hs = hs;
    chk("pkt_done", 32'(pkt_done), 32'(pend_done));
    chk("trunc_err", 32'(trunc_err), 32'(pend_trunc));
    if (pkt_done) n_done++;
    if (trunc_err) n_trunc++;
    pend_done = 0; pend_trunc = 0;
    drive();
  endtask

  task automatic run_drain(input int budget, input string tag);
    int n = 0;
    drive();
    while (!(all_empty() && !busy && !in_pkt) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_finished"}, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    in_pkt = 0; have_end = 0; pend_done = 0; pend_trunc = 0; s_hs = '0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
  endtask

  task automatic do_reset(input string tag);
    reset_8 = 1'b1;
    clear_model();
    m_tready = 1'b0;
    repeat (2) @(posedge clk_8);
    #1;
    chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_m_tid"}, 32'(m_tid), 32'd0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    chk({tag, "_trunc_err"}, 32'(trunc_err), 32'd0);
    reset_8 = 1'b0;
  endtask

  initial begin
    rdy_pat  = 4'b1001;
    reset_8  = 1'b0;
    m_tready = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    #2;
    do_reset("rst");

    // Single source, 5-byte packet.
    d0 = n_done; b0 = n_beats;
    add_pkt(0, 5, 1);
    run_drain(100, "t1");
    chk("t1_beats", 32'(n_beats - b0), 32'd5);
    chk("t1_done", 32'(n_done - d0), 32'd1);

    // All four sources continuously: strict rotation from src 0, one bubble each.
    do_reset("rst2");
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) add_pkt(s, 3, 16 * s + 4 * r);
    rr_check = 1; gap_check = 1; prev_tid = NS - 1;
    run_drain(200, "t2");
    rr_check = 0; gap_check = 0;
    chk("t2_last_tid", 32'(prev_tid), 32'd3);

    // Oversized packet: truncated at MAX, tail drained.
    d0 = n_done; t0 = n_trunc; b0 = n_beats;
    add_pkt(2, MAX + 6, -1);
    run_drain(3000, "t3");
    chk("t3_beats", 32'(n_beats - b0), 32'(MAX));
    chk("t3_trunc", 32'(n_trunc - t0), 32'd1);
    chk("t3_done", 32'(n_done - d0), 32'd0);
    chk("t3_src_drained", 32'(src_q[2].size()), 32'd0);

    // Exactly MAX bytes is a normal packet.
    d0 = n_done; t0 = n_trunc; b0 = n_beats;
    add_pkt(1, MAX, -1);
    run_drain(3000, "t4");
    chk("t4_beats", 32'(n_beats - b0), 32'(MAX));
    chk("t4_trunc", 32'(n_trunc - t0), 32'd0);
    chk("t4_done", 32'(n_done - d0), 32'd1);

    // Ready pattern 1,0,0,1 with gapped source valid, plus a single-byte packet.
    rdy_mode = 1; gap_pct = 30;
    add_pkt(3, 12, 8'h40);
    add_pkt(1, 1, 8'h99);
    run_drain(500, "t5a");
    rdy_mode = 0;

    // Random mix of sources, lengths, gaps and stalls.
    gap_pct = 25; stall_pct = 30;
    d0 = n_done; t0 = n_trunc;
    for (int p = 0; p < 40; p++) add_pkt($urandom_range(NS - 1), $urandom_range(24, 1), -1);
    add_pkt($urandom_range(NS - 1), MAX + 1 + $urandom_range(3), -1);
    run_drain(20000, "t5b");
    chk("t5b_done", 32'(n_done - d0), 32'd40);
    chk("t5b_trunc", 32'(n_trunc - t0), 32'd1);
    gap_pct = 0; stall_pct = 0;

    // Reset while byte 3 of a packet is on the lane.
    do_reset("rst6");
    add_pkt(2, 8, 8'h70);
    begin
      int n = 0;
      drive();
      while (!(in_pkt && pos == 2) && n < 50) begin
        cycle();
        n++;
      end
      chk("t6_reach_byte3", 32'(n < 50), 32'd1);
    end
    chk("t6_pre_valid", 32'(m_tvalid), 32'd1);
    #2;
    reset_8 = 1'b1;
    #1;
    chk("t6_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_s_tready", 32'(s_tready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_m_tdata", 32'(m_tdata), 32'd0);
    clear_model();
    @(posedge clk_8); #1;
    chk("t6_hold_done", 32'(pkt_done), 32'd0);
    reset_8 = 1'b0;
    add_pkt(1, 4, 8'hA0);
    add_pkt(0, 4, 8'hB0);
    rr_check = 1; prev_tid = NS - 1;
    run_drain(100, "t6");
    rr_check = 0;
    chk("t6_last_tid", 32'(prev_tid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
